// File: rtl/ntt_cmd_dispatcher_if.sv
// Host push channel, engine command channel and status for ntt_cmd_dispatcher.
// err_timeout exists only when NTT_DISPATCH_TIMEOUT_EN is defined.
interface ntt_cmd_dispatcher_if #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned CNT_W   = 16
);
    logic              push_valid;
    logic              push_ready;
    logic [7:0]        push_opcode;
    logic [3:0]        push_slot;
    logic [47:0]       push_addr;
    logic              eng_ready;
    logic              cmd_valid;
    logic [7:0]        cmd_opcode;
    logic [3:0]        cmd_slot;
    logic [47:0]       cmd_dma_addr;
    logic [FIFO_AW:0]  fifo_count;
    logic              busy;
    logic [CNT_W-1:0]  done_count;
    logic              err_illegal;
`ifdef NTT_DISPATCH_TIMEOUT_EN
    logic              err_timeout;
`endif

    // Dispatcher side
    modport master (
        input  push_valid, push_opcode, push_slot, push_addr, eng_ready,
        output push_ready, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr,
        output fifo_count, busy, done_count, err_illegal
`ifdef NTT_DISPATCH_TIMEOUT_EN
        , output err_timeout
`endif
    );

    // Host / engine side
    modport slave (
        output push_valid, push_opcode, push_slot, push_addr, eng_ready,
        input  push_ready, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr,
        input  fifo_count, busy, done_count, err_illegal
`ifdef NTT_DISPATCH_TIMEOUT_EN
        , input err_timeout
`endif
    );
endinterface

// File: rtl/ntt_cmd_dispatcher.sv
// Command FIFO plus issue pacing toward ntt_engine; drops illegal opcodes.
// Optional S_WAIT watchdog enabled by NTT_DISPATCH_TIMEOUT_EN.
module ntt_cmd_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3,
    parameter int unsigned CNT_W      = 16
`ifdef NTT_DISPATCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 20000
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ntt_cmd_dispatcher_if.master bus
);
    localparam int unsigned OP_W   = 8;
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned ADDR_W = 48;
    localparam int unsigned CNT_AW = FIFO_AW + 1;

    localparam logic [OP_W-1:0] OP_LOAD   = 8'h02;
    localparam logic [OP_W-1:0] OP_STORE  = 8'h03;
    localparam logic [OP_W-1:0] OP_LOAD_W = 8'h04;
    localparam logic [OP_W-1:0] OP_NTT    = 8'h10;
    localparam logic [OP_W-1:0] OP_INTT   = 8'h11;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SLOT_W-1:0] slot;
        logic [OP_W-1:0]   opcode;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    cmd_t               fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_AW-1:0]  count_q, count_d;
    logic               push_ready_q, push_ready_d;
    logic               busy_q, busy_d;
    cmd_t               cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               err_illegal_q, err_illegal_d;
    logic [CNT_W-1:0]   done_q, done_d;

    cmd_t               push_cmd_c, head_c;
    logic               push_fire_c, pop_c, head_legal_c, timeout_c;

    assign push_cmd_c   = {bus.push_addr, bus.push_slot, bus.push_opcode};
    assign push_fire_c  = bus.push_valid && push_ready_q;
    assign head_c       = fifo_mem_q[rd_ptr_q];
    assign head_legal_c = head_c.opcode inside {OP_LOAD, OP_STORE, OP_LOAD_W, OP_NTT, OP_INTT};

`ifdef NTT_DISPATCH_TIMEOUT_EN
    localparam int unsigned WD_W = 16;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_timeout_q;
`endif

    // FIFO storage; contents need no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (push_fire_c) begin
            fifo_mem_q[wr_ptr_q] <= push_cmd_c;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop_c && head_legal_c) state_d = S_ISSUE;
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  state_d = S_WAIT;
            S_WAIT:  if (bus.eng_ready || timeout_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath decode; eng_ready is deliberately ignored in S_HOLD
    always_comb begin
        pop_c         = 1'b0;
        timeout_c     = 1'b0;
        cmd_d         = cmd_q;
        cmd_valid_d   = 1'b0;
        err_illegal_d = 1'b0;
        done_d        = done_q;
        case (state_q)
            S_IDLE: begin
                pop_c = (count_q != '0) && bus.eng_ready;
                if (pop_c) begin
                    if (head_legal_c) begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = head_c;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.eng_ready) begin
                    done_d = done_q + CNT_W'(1);
                end
`ifdef NTT_DISPATCH_TIMEOUT_EN
                timeout_c = !bus.eng_ready && (wd_q == WD_W'(TIMEOUT_CYC));
`endif
            end
            default: ;
        endcase
    end

    // Occupancy; a full FIFO stays not-ready for the cycle of a pop
    always_comb begin
        count_d      = count_q + CNT_AW'(push_fire_c) - CNT_AW'(pop_c);
        push_ready_d = (count_d != CNT_AW'(FIFO_DEPTH));
        busy_d       = (count_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            push_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
            done_q        <= '0;
        end else begin
            if (push_fire_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop_c)       rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q       <= count_d;
            push_ready_q  <= push_ready_d;
            busy_q        <= busy_d;
            cmd_q         <= cmd_d;
            cmd_valid_q   <= cmd_valid_d;
            err_illegal_q <= err_illegal_d;
            done_q        <= done_d;
        end
    end

`ifdef NTT_DISPATCH_TIMEOUT_EN
    // Watchdog counts S_WAIT cycles, starting at 1 on entry
    always_comb begin
        wd_d = wd_q;
        if (state_q == S_HOLD) begin
            wd_d = WD_W'(1);
        end else if (state_q == S_WAIT && state_d == S_WAIT) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            err_timeout_q <= timeout_c;
        end
    end

    assign bus.err_timeout = err_timeout_q;
`endif

    assign bus.push_ready   = push_ready_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_opcode   = cmd_q.opcode;
    assign bus.cmd_slot     = cmd_q.slot;
    assign bus.cmd_dma_addr = cmd_q.addr;
    assign bus.fifo_count   = count_q;
    assign bus.busy         = busy_q;
    assign bus.done_count   = done_q;
    assign bus.err_illegal  = err_illegal_q;
endmodule

// File: doc/ntt_cmd_dispatcher.md
Name: ntt_cmd_dispatcher

Overview:
- Initiator side of the NTT engine command interface.
- Buffers host-issued commands in a FIFO and presents them one at a time on cmd_valid/cmd_opcode/cmd_slot/cmd_dma_addr.
- Paces issue against the engine's ready, which drops one cycle after accept and returns when the engine is back in idle.
- Sits between the host/sequencer and ntt_engine, and reports progress and illegal-opcode drops.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- FIFO_AW, 3, log2(FIFO_DEPTH).
- CNT_W, 16, width of done_count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- push_valid  in  1  host offers a command.
- push_ready  out  1  FIFO can accept; a push occurs when push_valid && push_ready.
- push_opcode  in  8  command opcode.
- push_slot  in  4  slot field.
- push_addr  in  48  DMA byte address.
- eng_ready  in  1  engine ready level.
- cmd_valid  out  1  one-cycle command strobe to the engine.
- cmd_opcode  out  8  registered opcode.
- cmd_slot  out  4  registered slot.
- cmd_dma_addr  out  48  registered address.
- fifo_count  out  FIFO_AW+1  occupied entries.
- busy  out  1  FIFO non-empty or FSM not in S_IDLE.
- done_count  out  CNT_W  completed engine commands; wraps at 2^CNT_W.
- err_illegal  out  1  one-cycle pulse when a popped opcode is dropped.

Behaviour:
- Only clk is used. All state updates on the rising edge. rst_n=0 sampled at an edge resets everything, including mid-command.
- Reset values: push_ready=1, cmd_valid=0, cmd_opcode=0, cmd_slot=0, cmd_dma_addr=0, fifo_count=0, busy=0, done_count=0, err_illegal=0. FSM goes to S_IDLE and FIFO pointers go to 0.
- Legal opcodes are 8'h02 LOAD, 8'h03 STORE, 8'h04 LOAD_W, 8'h10 NTT and 8'h11 INTT. Any other opcode is illegal.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers that wrap naturally.
  - push_ready = (fifo_count != FIFO_DEPTH), derived from the registered count.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, push_ready=0 even if a pop occurs that cycle; the freed slot is visible next cycle.
  - A push while full is ignored.
- FSM states: S_IDLE, S_ISSUE, S_HOLD, S_WAIT.
- S_IDLE:
  - Pops the head when fifo_count!=0 and eng_ready=1.
  - Illegal opcode: entry discarded, err_illegal=1 next cycle, FSM stays in S_IDLE. The next pop may occur the following cycle.
  - Legal opcode: fields latched into cmd_* and cmd_valid=1 next cycle; go to S_ISSUE.
- S_ISSUE: cmd_valid is high for exactly this one cycle; go to S_HOLD. cmd_* hold their value until the next issue.
- S_HOLD: one cycle; eng_ready is ignored (the engine's ready fall lags the accept by a cycle); go to S_WAIT.
- S_WAIT:
  - On eng_ready=1, done_count increments and the FSM returns to S_IDLE.
  - The next command cannot be popped before the following cycle.
  - No timeout unless the optional feature is enabled.
- Latency: a push at edge k reaches cmd_valid=1 at edge k+2 at the earliest (FIFO empty, FSM in S_IDLE, eng_ready=1).
- Minimum spacing between successive cmd_valid pulses is 4 cycles. Against the engine a LOAD or STORE spacing is 5 cycles.
- busy = (fifo_count!=0) || (state!=S_IDLE).

Optional Feature:
- Macro: NTT_DISPATCH_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYC, default 20000, and a 16-bit watchdog that counts cycles spent in S_WAIT.
  - When the count reaches TIMEOUT_CYC, output err_timeout pulses for one cycle, the FSM returns to S_IDLE and done_count does not increment.
  - The watchdog clears on every entry to S_WAIT.
- When undefined: no err_timeout port, no counter, and S_WAIT waits indefinitely.

Test Plan:
- Reset, then push LOAD (02, slot 1, addr 0x1000) with eng_ready held 1 → cmd_valid for exactly one cycle 2 cycles after the push, with cmd_opcode=02, cmd_slot=1 and cmd_dma_addr=0x1000. After eng_ready goes 0 and then back to 1, done_count=1.
- Push 9 commands back-to-back into the depth-8 FIFO with eng_ready=0 → push_ready=0 after the 8th; the 9th is not accepted; fifo_count=8.
- Push opcode 8'h55, then NTT (10) → err_illegal pulses once, no cmd_valid for 8'h55, then one cmd_valid with opcode 10.
- Model the engine ready profile (low 2 cycles for DMA ops, low 4096+ cycles for NTT) across the sequence LOAD_W, LOAD, NTT, INTT, STORE → issue order is preserved, no cmd_valid while ready is low, final done_count=5.
- Assert rst_n=0 in S_WAIT with 3 entries queued → next cycle fifo_count=0, busy=0, cmd_valid=0, done_count=0.
- With NTT_DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=100, hold eng_ready=0 after an issue → err_timeout pulses at the 100th S_WAIT cycle, the FSM is back in S_IDLE, and done_count is unchanged.
